// File: rtl/matrix_mac_seq_if.sv
// rtl/matrix_mac_seq_if.sv - operand/result bundle with start/busy/done handshake for matrix_mac_seq
interface matrix_mac_seq_if #(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int ACCW = 18
) ();
  logic                  start;
  logic                  signed_mode;
  logic                  acc_mode;
  logic [N*N*DW-1:0]     a_flat;
  logic [N*N*DW-1:0]     b_flat;
  logic [N*N*ACCW-1:0]   c_flat;
  logic                  busy;
  logic                  done;

  modport master (
    output start, signed_mode, acc_mode, a_flat, b_flat,
    input  c_flat, busy, done
  );

  modport slave (
    input  start, signed_mode, acc_mode, a_flat, b_flat,
    output c_flat, busy, done
  );
endinterface

// File: rtl/matrix_mac_seq.sv
// rtl/matrix_mac_seq.sv - multi-cycle NxN matrix multiply-accumulate, one row of N MAC lanes per step
// Operands are captured on accept; row i, inner index k advance one step per cycle.
module matrix_mac_seq #(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int ACCW = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  matrix_mac_seq_if.slave  bus
);
  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  generate
    if (N < 2 || ACCW < 2 * DW + $clog2(N)) begin : g_bad_params
      $error("matrix_mac_seq: need N >= 2 and ACCW >= 2*DW + clog2(N)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     w_a_in [N][N];
  logic [DW-1:0]     w_b_in [N][N];
  logic [DW-1:0]     r_a    [N][N];
  logic [DW-1:0]     r_b    [N][N];
  logic [ACCW-1:0]   r_acc  [N][N];
  logic [ACCW-1:0]   r_c    [N][N];
  logic [ACCW-1:0]   w_prod [N];
  logic [ACCW-1:0]   w_a_ext;
  logic              r_signed;
  logic              r_done;
  logic [CW-1:0]     r_i;
  logic [CW-1:0]     r_k;
  logic              w_last;

  function automatic logic [ACCW-1:0] ext(input logic [DW-1:0] x, input logic s);
    return s ? {{(ACCW-DW){x[DW-1]}}, x} : {{(ACCW-DW){1'b0}}, x};
  endfunction

  generate
    for (genvar gr = 0; gr < N; gr++) begin : g_row
      for (genvar gc = 0; gc < N; gc++) begin : g_col
        assign w_a_in[gr][gc] = bus.a_flat[(gr*N+gc)*DW +: DW];
        assign w_b_in[gr][gc] = bus.b_flat[(gr*N+gc)*DW +: DW];
        assign bus.c_flat[(gr*N+gc)*ACCW +: ACCW] = r_c[gr][gc];
      end
    end
  endgenerate

  // One A element is shared by every column lane in the current step.
  always_comb begin
    w_a_ext = ext(r_a[r_i][r_k], r_signed);
    for (int j = 0; j < N; j++) begin
      w_prod[j] = w_a_ext * ext(r_b[r_k][j], r_signed);
    end
  end

  assign w_last   = (r_i == LAST) && (r_k == LAST);
  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = COMPUTE;
      COMPUTE: if (w_last)    w_next = FINISH;
      FINISH:                 w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i      <= '0;
      r_k      <= '0;
      r_signed <= 1'b0;
      r_done   <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_a[r][c]   <= '0;
          r_b[r][c]   <= '0;
          r_acc[r][c] <= '0;
          r_c[r][c]   <= '0;
        end
      end
    end else begin
      r_done <= (r_state == FINISH);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_signed <= bus.signed_mode;
            r_i      <= '0;
            r_k      <= '0;
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                r_a[r][c]   <= w_a_in[r][c];
                r_b[r][c]   <= w_b_in[r][c];
                r_acc[r][c] <= bus.acc_mode ? r_c[r][c] : '0;
              end
            end
          end
        end
        COMPUTE: begin
          for (int j = 0; j < N; j++) begin
            r_acc[r_i][j] <= r_acc[r_i][j] + w_prod[j];
          end
          if (r_k == LAST) begin
            r_k <= '0;
            r_i <= w_last ? '0 : r_i + 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        FINISH: begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              r_c[r][c] <= r_acc[r][c];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_mac_seq.sv
// tb/tb_matrix_mac_seq.sv - randomized and directed bench for matrix_mac_seq against an arithmetic model
module tb_matrix_mac_seq;
  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int ACCW = 18;
  localparam int NN   = N * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_mac_seq_if #(.N(N), .DW(DW), .ACCW(ACCW)) bus ();
  matrix_mac_seq #(.N(N), .DW(DW), .ACCW(ACCW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]   ma [NN];
  logic [DW-1:0]   mb [NN];
  logic [ACCW-1:0] exp_c [NN];

  int lat, bcnt, dcnt;
  bit tmo;

  function automatic longint ev(input logic [DW-1:0] x, input bit s);
    return s ? longint'($signed(x)) : longint'(x);
  endfunction

  // Reference: C = (acc ? C : 0) + A*B, reduced modulo 2^ACCW.
  task automatic model(input bit s, input bit acc);
    logic [ACCW-1:0] nxt [NN];
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        longint sum;
        sum = acc ? longint'(exp_c[r*N+c]) : 64'sd0;
        for (int k = 0; k < N; k++) sum += ev(ma[r*N+k], s) * ev(mb[k*N+c], s);
        nxt[r*N+c] = sum[ACCW-1:0];
      end
    end
    for (int i = 0; i < NN; i++) exp_c[i] = nxt[i];
  endtask

  function automatic logic [NN*ACCW-1:0] exp_flat();
    logic [NN*ACCW-1:0] v;
    for (int i = 0; i < NN; i++) v[i*ACCW +: ACCW] = exp_c[i];
    return v;
  endfunction

  // Drives one operation from a negedge and returns at the negedge where done is seen.
  task automatic run_op(input bit s, input bit acc, input int pulse_at,
                        output int o_lat, output int o_bcnt, output bit o_tmo);
    for (int i = 0; i < NN; i++) begin
      bus.a_flat[i*DW +: DW] = ma[i];
      bus.b_flat[i*DW +: DW] = mb[i];
    end
    bus.signed_mode = s;
    bus.acc_mode    = acc;
    bus.start       = 1'b1;
    o_lat  = -1;
    o_bcnt = 0;
    o_tmo  = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == pulse_at);
      bus.a_flat = {NN*DW{1'b1}} ^ bus.a_flat;
      bus.b_flat = ~bus.b_flat;
      bus.signed_mode = ~s;
      bus.acc_mode = ~acc;
      if (bus.busy) o_bcnt++;
      if (bus.done) begin
        o_lat = cyc - 1;
        o_tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NN; i++) exp_c[i] = '0;
    for (int cyc = 0; cyc < 21; cyc++) begin
      total++;
      if (bus.c_flat !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got c=%h busy=%b done=%b want c=0 busy=0 done=0",
                 cyc, bus.c_flat, bus.busy, bus.done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i % (N + 1) == 0) ? 8'd1 : 8'd0;
      mb[i] = DW'(i + 1);
    end
    run_op(1'b0, 1'b0, 0, lat, bcnt, tmo);
    model(1'b0, 1'b0);
    total++;
    if (tmo || lat != 10) begin
      bad++;
      $display("FAIL identity_latency got %0d (timeout=%0b) want 10", lat, tmo);
    end
    total++;
    if (bcnt != 10) begin bad++; $display("FAIL identity_busy_cycles got %0d want 10", bcnt); end
    total++;
    if (bus.c_flat !== exp_flat()) begin
      bad++;
      $display("FAIL identity_result got %h want %h", bus.c_flat, exp_flat());
    end
    total++;
    if (bus.c_flat[8*ACCW +: ACCW] !== 18'd9) begin
      bad++;
      $display("FAIL identity_c22 got %0d want 9", bus.c_flat[8*ACCW +: ACCW]);
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL identity_busy_at_done got %b want 0", bus.busy); end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL identity_done_width got %b want 0", bus.done); end
  endtask

  task automatic test_max_unsigned();
    for (int i = 0; i < NN; i++) begin ma[i] = 8'hFF; mb[i] = 8'hFF; end
    run_op(1'b0, 1'b0, 0, lat, bcnt, tmo);
    model(1'b0, 1'b0);
    total++;
    if (tmo || bus.c_flat !== exp_flat()) begin
      bad++;
      $display("FAIL max_unsigned got %h want %h (timeout=%0b)", bus.c_flat, exp_flat(), tmo);
    end
    total++;
    if (bus.c_flat[4*ACCW +: ACCW] !== 18'h2FA03) begin
      bad++;
      $display("FAIL max_unsigned_c11 got %h want 2fa03", bus.c_flat[4*ACCW +: ACCW]);
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    for (int i = 0; i < NN; i++) begin ma[i] = 8'h80; mb[i] = 8'h80; end
    run_op(1'b1, 1'b0, 0, lat, bcnt, tmo);
    model(1'b1, 1'b0);
    total++;
    if (tmo || bus.c_flat !== exp_flat() || bus.c_flat[0 +: ACCW] !== 18'd49152) begin
      bad++;
      $display("FAIL signed_min got %h want %h", bus.c_flat, exp_flat());
    end
    @(negedge clk);
    for (int i = 0; i < NN; i++) begin ma[i] = 8'hFF; mb[i] = 8'h01; end
    run_op(1'b1, 1'b0, 0, lat, bcnt, tmo);
    model(1'b1, 1'b0);
    total++;
    if (tmo || bus.c_flat !== exp_flat() || bus.c_flat[5*ACCW +: ACCW] !== 18'h3FFFD) begin
      bad++;
      $display("FAIL signed_neg got %h want %h", bus.c_flat, exp_flat());
    end
    @(negedge clk);
  endtask

  task automatic test_accumulate();
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i % (N + 1) == 0) ? 8'd1 : 8'd0;
      mb[i] = 8'd2;
    end
    run_op(1'b0, 1'b0, 0, lat, bcnt, tmo);
    model(1'b0, 1'b0);
    total++;
    if (tmo || bus.c_flat !== exp_flat()) begin
      bad++;
      $display("FAIL acc_first got %h want %h", bus.c_flat, exp_flat());
    end
    @(negedge clk);
    run_op(1'b0, 1'b1, 5, lat, bcnt, tmo);
    model(1'b0, 1'b1);
    total++;
    if (tmo || lat != 10 || bus.c_flat !== exp_flat() || bus.c_flat[0 +: ACCW] !== 18'd4) begin
      bad++;
      $display("FAIL acc_second got %h lat=%0d want %h lat=10", bus.c_flat, lat, exp_flat());
    end
    // Back-to-back: start raised in the done cycle itself.
    run_op(1'b0, 1'b1, 0, lat, bcnt, tmo);
    model(1'b0, 1'b1);
    total++;
    if (tmo || lat + 1 != 11) begin
      bad++;
      $display("FAIL back_to_back_gap got %0d (timeout=%0b) want 11", lat + 1, tmo);
    end
    total++;
    if (bus.c_flat !== exp_flat()) begin
      bad++;
      $display("FAIL back_to_back_result got %h want %h", bus.c_flat, exp_flat());
    end
    dcnt = 0;
    repeat (15) begin @(negedge clk); if (bus.done) dcnt++; end
    total++;
    if (dcnt != 0) begin bad++; $display("FAIL no_extra_done got %0d want 0", dcnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NN; i++) begin ma[i] = DW'($urandom); mb[i] = DW'($urandom); end
    for (int i = 0; i < NN; i++) bus.a_flat[i*DW +: DW] = ma[i];
    for (int i = 0; i < NN; i++) bus.b_flat[i*DW +: DW] = mb[i];
    bus.signed_mode = 1'b0;
    bus.acc_mode    = 1'b1;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NN; i++) exp_c[i] = '0;
    total++;
    if (bus.c_flat !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state got c=%h busy=%b done=%b want 0/0/0", bus.c_flat, bus.busy, bus.done);
    end
    dcnt = 0;
    repeat (15) begin @(negedge clk); if (bus.done) dcnt++; end
    total++;
    if (dcnt != 0) begin bad++; $display("FAIL reset_mid_done got %0d want 0", dcnt); end
    run_op(1'b1, 1'b1, 0, lat, bcnt, tmo);
    model(1'b1, 1'b1);
    total++;
    if (tmo || bus.c_flat !== exp_flat()) begin
      bad++;
      $display("FAIL reset_mid_fresh got %h want %h", bus.c_flat, exp_flat());
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      bit s, acc;
      s   = 1'($urandom);
      acc = 1'($urandom);
      for (int i = 0; i < NN; i++) begin ma[i] = DW'($urandom); mb[i] = DW'($urandom); end
      run_op(s, acc, (t % 3 == 0) ? 4 : 0, lat, bcnt, tmo);
      model(s, acc);
      total++;
      if (tmo || lat != 10 || bus.c_flat !== exp_flat()) begin
        bad++;
        $display("FAIL random_%0d s=%0b acc=%0b got %h lat=%0d want %h lat=10",
                 t, s, acc, bus.c_flat, lat, exp_flat());
      end
      if (t % 2 == 0) @(negedge clk);
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.acc_mode    = 1'b0;
    bus.a_flat      = '0;
    bus.b_flat      = '0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_max_unsigned();
    test_signed();
    test_accumulate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
